melody_play_ctrl: RTL and testbench
===================================

// Module: melody_play_ctrl
// PURPOSE
//  Sequencer for the 8-slot melody store. It snapshots a packed 32-bit melody and plays
//  notes 0..max_index one at a time on the piezo note bus, with timed note and gap phases.
//  It also arbitrates between full-melody playback and single-note answer preview.
//  Sits between the game/button logic and the piezo tone generator.
// PARAMETERS
//  NOTE_TICKS  5000000  clk cycles a note is held on piezo_note (>=1)
//  GAP_TICKS   5000000  clk cycles of silence after each note (>=1)
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  reset         in   1   asynchronous, active-low reset
//  melody        in   32  packed notes; slot i = melody[4*i+3:4*i], 0 = rest
//  max_index     in   3   last slot played by a full playback (0..7)
//  play_req      in   1   level, sampled each clk; start full playback when idle
//  preview_req   in   1   level, sampled each clk; start one-note preview when idle
//  preview_idx   in   3   slot played by a preview
//  abort         in   1   stop any activity; return to IDLE next cycle
//  piezo_note    out  4   note code to tone generator, 0 = silent
//  note_idx      out  3   slot currently playing (0 when idle)
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse when playback or preview completes normally
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; piezo_note=0, note_idx=0, busy=0, done=0; counters cleared.
//   Takes effect immediately, including mid-note.
//  States: IDLE, NOTE, GAP, PREVIEW, DONE.
//  IDLE: if play_req=1 -> NOTE.
//   - Capture melody and max_index into shadow registers; set note_idx=0.
//   - Else if preview_req=1 -> PREVIEW; capture melody and preview_idx.
//   - play_req wins when both are high.
//  Latency: request sampled at edge k -> piezo_note shows the note at k+1.
//  NOTE: piezo_note = shadow slot[note_idx] for exactly NOTE_TICKS cycles, then -> GAP.
//   A rest (code 0) still takes its full slot time.
//  GAP: piezo_note=0 for exactly GAP_TICKS cycles. Then:
//   - if note_idx == shadow max_index -> DONE;
//   - else note_idx+1 -> NOTE.
//  PREVIEW: piezo_note = shadow slot[preview_idx] for NOTE_TICKS cycles -> DONE.
//   note_idx = preview_idx during preview. No gap phase.
//  DONE: single cycle; done=1, piezo_note=0, busy=1 -> IDLE with note_idx=0.
//  Requests while busy are ignored and not queued.
//   A request still high in IDLE after DONE restarts the sequence (level-sensitive).
//  abort=1 in any non-IDLE state -> IDLE next edge:
//   - piezo_note=0, busy=0, no done pulse;
//   - abort has priority over tick expiry in the same cycle;
//   - abort in IDLE has no effect, and blocks a same-cycle start.
//  Snapshot rule: melody/max_index/preview_idx changes during busy do not affect the
//   current run.
//  Arithmetic:
//   - tick counter width is $clog2(max(NOTE_TICKS,GAP_TICKS)+1);
//   - counter reloads on every phase entry;
//   - note_idx is 3 bits, and max_index=7 plays all 8 slots with no wrap.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
// TESTING (NOTE_TICKS=4, GAP_TICKS=2)
//  1 melody=32'h87654321, max_index=2, play_req pulse
//    -> piezo_note 1,1,1,1,0,0,2x4,0x2,3x4,0x2; then done=1 one cycle; busy falls.
//  2 max_index=7, melody=32'h80000001 -> slots 1..6 silent for 4 cycles each;
//    slot 7 = 8; done after cycle 48+1.
//  3 play_req and preview_req high the same cycle -> full playback runs; preview ignored.
//  4 preview_idx=5, melody=32'h00A00000, preview_req
//    -> piezo_note=A for 4 cycles, note_idx=5, then done.
//  5 abort during second NOTE of test 1 -> next cycle piezo_note=0, busy=0, no done.
//  6 reset low during GAP -> outputs 0 immediately.
//    After release, play_req restarts from slot 0; change melody mid-run -> old notes
//    keep playing.

Source files
------------

// File: rtl/melody_play_ctrl.sv
// Melody sequencer: snapshots a packed 8-slot melody and plays it on the piezo
// note bus with timed note/gap phases, or previews a single slot.
module melody_play_ctrl #(
  parameter int NOTE_TICKS = 5000000,
  parameter int GAP_TICKS  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] melody,
  input  logic [2:0]  max_index,
  input  logic        play_req,
  input  logic        preview_req,
  input  logic [2:0]  preview_idx,
  input  logic        abort,
  output logic [3:0]  piezo_note,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_NOTE, S_GAP, S_PREVIEW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mel_q, mel_d;
  logic [2:0]    max_q, max_d;
  logic [2:0]    note_idx_q, note_idx_d;
  logic [3:0]    piezo_q, piezo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [3:0] slot(input logic [31:0] m, input logic [2:0] i);
    return m[{i, 2'b00} +: 4];
  endfunction

  // Outputs are computed from the next state so they appear with the state change.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mel_d      = mel_q;
    max_d      = max_q;
    note_idx_d = note_idx_q;
    piezo_d    = 4'd0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d     = 1'b0;
        note_idx_d = 3'd0;
        if (!abort && play_req) begin
          state_d    = S_NOTE;
          mel_d      = melody;
          max_d      = max_index;
          cnt_d      = NOTE_LOAD;
          piezo_d    = slot(melody, 3'd0);
          busy_d     = 1'b1;
        end else if (!abort && preview_req) begin
          state_d    = S_PREVIEW;
          mel_d      = melody;
          note_idx_d = preview_idx;
          cnt_d      = NOTE_LOAD;
          piezo_d    = slot(melody, preview_idx);
          busy_d     = 1'b1;
        end
      end
      S_NOTE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          piezo_d = slot(mel_q, note_idx_q);
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (note_idx_q == max_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_NOTE;
          note_idx_d = note_idx_q + 3'd1;
          cnt_d      = NOTE_LOAD;
          piezo_d    = slot(mel_q, note_idx_q + 3'd1);
        end
      end
      S_PREVIEW: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          piezo_d = slot(mel_q, note_idx_q);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        note_idx_d = 3'd0;
        busy_d     = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        note_idx_d = 3'd0;
        busy_d     = 1'b0;
      end
    endcase

    // Abort overrides any tick expiry decided above.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      note_idx_d = 3'd0;
      piezo_d    = 4'd0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mel_q      <= '0;
      max_q      <= '0;
      note_idx_q <= '0;
      piezo_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mel_q      <= mel_d;
      max_q      <= max_d;
      note_idx_q <= note_idx_d;
      piezo_q    <= piezo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign piezo_note = piezo_q;
  assign note_idx   = note_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_melody_play_ctrl.sv
// Scoreboard bench for melody_play_ctrl: a list-based melody model pushes the
// expected per-cycle output trace, a negedge monitor pops it while busy/done.
module tb_melody_play_ctrl;
  localparam int NT = 4;
  localparam int GT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] melody;
  logic [2:0]  max_index;
  logic        play_req;
  logic        preview_req;
  logic [2:0]  preview_idx;
  logic        abort;
  logic [3:0]  piezo_note;
  logic [2:0]  note_idx;
  logic        busy;
  logic        done;

  melody_play_ctrl #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .melody(melody), .max_index(max_index),
    .play_req(play_req), .preview_req(preview_req), .preview_idx(preview_idx),
    .abort(abort), .piezo_note(piezo_note), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] idx;
    logic       chk_idx;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] slot_of(input logic [31:0] m, input int i);
    logic [31:0] t;
    t = m >> (4 * i);
    return t[3:0];
  endfunction

  function automatic int run_len(input int kind, input int mx);
    return (kind == 1) ? NT + 1 : (mx + 1) * (NT + GT) + 1;
  endfunction

  // Reference: a play is, per slot, NT cycles of the note then GT silent cycles,
  // followed by one done cycle; a preview is NT cycles of one slot then done.
  task automatic model_push(input int kind, input logic [31:0] m, input int mx,
                            input int pidx, input int cut);
    exp_t tr[$];
    exp_t e;
    if (kind == 1) begin
      for (int k = 0; k < NT; k++) begin
        e = '{note: slot_of(m, pidx), idx: 3'(pidx), chk_idx: 1'b1, done: 1'b0};
        tr.push_back(e);
      end
    end else begin
      for (int i = 0; i <= mx; i++) begin
        for (int k = 0; k < NT; k++) begin
          e = '{note: slot_of(m, i), idx: 3'(i), chk_idx: 1'b1, done: 1'b0};
          tr.push_back(e);
        end
        for (int k = 0; k < GT; k++) begin
          e = '{note: 4'd0, idx: 3'(i), chk_idx: 1'b1, done: 1'b0};
          tr.push_back(e);
        end
      end
    end
    e = '{note: 4'd0, idx: 3'd0, chk_idx: 1'b0, done: 1'b1};
    tr.push_back(e);
    foreach (tr[j]) begin
      if (cut < 0 || j < cut) exp_q.push_back(tr[j]);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (busy || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: note=%0h idx=%0d busy=%0b done=%0b, required none",
                 piezo_note, note_idx, busy, done);
      end else begin
        mon_e = exp_q.pop_front();
        if (piezo_note !== mon_e.note || done !== mon_e.done || busy !== 1'b1 ||
            (mon_e.chk_idx && note_idx !== mon_e.idx)) begin
          errors++;
          $display("FAIL scoreboard @%0t: note=%0h idx=%0d busy=%0b done=%0b, required note=%0h idx=%0d busy=1 done=%0b",
                   $time, piezo_note, note_idx, busy, done, mon_e.note, mon_e.idx, mon_e.done);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (piezo_note !== 4'd0 || note_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: note=%0h idx=%0d busy=%0b done=%0b, required all zero",
               name, piezo_note, note_idx, busy, done);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (!busy && !done) break;
      n++;
    end
    checks++;
    if (busy || done) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d outputs outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    check_idle({name, "_idle"});
  endtask

  // kind: 0 play, 1 preview, 2 both requests together (play must win).
  task automatic run(input string name, input int kind, input logic [31:0] m,
                     input logic [2:0] mx, input logic [2:0] pidx,
                     input int abort_at, input bit scramble);
    int last_c;
    @(posedge clk); #1;
    melody      = m;
    max_index   = mx;
    preview_idx = pidx;
    play_req    = (kind != 1);
    preview_req = (kind != 0);
    model_push(kind, m, int'(mx), int'(pidx), (abort_at < 0) ? -1 : abort_at + 1);
    $display("run %s: kind=%0d melody=%h max=%0d pidx=%0d abort_at=%0d scramble=%0b",
             name, kind, m, mx, pidx, abort_at, scramble);
    last_c = (abort_at < 0) ? 1 : abort_at + 1;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      play_req    = 1'b0;
      preview_req = scramble && (c == 0);
      abort       = (c == abort_at);
      if (scramble && c == 0) begin
        melody      = $urandom;
        max_index   = 3'($urandom);
        preview_idx = 3'($urandom);
      end
    end
    wait_idle(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, mx, len, ab;
    reset = 1'b0;
    melody = '0; max_index = '0; play_req = 0; preview_req = 0; preview_idx = '0; abort = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    reset = 1'b1;

    run("t1_play3", 0, 32'h87654321, 3'd2, 3'd0, -1, 1'b0);
    run("t2_play8", 0, 32'h80000001, 3'd7, 3'd0, -1, 1'b0);
    run("t3_both", 2, 32'h1234ABCD, 3'd1, 3'd6, -1, 1'b0);
    run("t4_preview", 1, 32'h00A00000, 3'd0, 3'd5, -1, 1'b0);
    run("t5_abort", 0, 32'h87654321, 3'd2, 3'd0, 7, 1'b0);
    run("abort_in_done", 0, 32'h00000055, 3'd0, 3'd0, NT + GT, 1'b0);

    // Reset asserted mid-gap clears outputs without waiting for a clock edge.
    @(posedge clk); #1;
    melody = 32'h87654321; max_index = 3'd2; play_req = 1'b1;
    model_push(0, 32'h87654321, 2, 0, -1);
    @(posedge clk); #1;
    play_req = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_idle("t6_async_reset");
    exp_q.delete();
    $display("run t6_reset: reset asserted during gap");
    @(posedge clk); #1;
    reset = 1'b1;
    run("t6_restart", 0, 32'h00000321, 3'd2, 3'd0, -1, 1'b1);

    // A request held through DONE restarts after one idle cycle.
    @(posedge clk); #1;
    melody = 32'h000009C5; max_index = 3'd2; play_req = 1'b1;
    model_push(0, 32'h000009C5, 2, 0, -1);
    model_push(0, 32'h000009C5, 2, 0, -1);
    $display("run held_req: play_req held across two runs");
    repeat (run_len(0, 2) + 2) @(posedge clk);
    #1 play_req = 1'b0;
    wait_idle("held_req");

    @(posedge clk); #1;
    play_req = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    play_req = 1'b0; abort = 1'b0;
    @(negedge clk);
    $display("run abort_idle: abort with play_req in idle");
    check_idle("abort_idle_blocks_start");

    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 2);
      mx   = $urandom_range(0, 7);
      len  = run_len(kind, mx);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run("random", kind, $urandom, 3'(mx), 3'($urandom), ab, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
